// File: rtl/fixed_addsub_pipe.sv
// Two-stage, multi-lane signed fixed-point add/subtract unit with valid/ready
// streaming on both sides, per-lane N/V/Z flags and a sticky overflow bit.
// Stage 1 forms the (W+1)-bit exact sum per lane; stage 2 clamps or wraps it
// to W bits and derives the flags. Operands are whole W-bit words, so
// fraction carries/borrows flow into the integer part naturally.
module fixed_addsub_pipe #(
    parameter int INT_BITS  = 8,
    parameter int FRAC_BITS = 8,
    parameter int LANES     = 4,
    parameter int SATURATE  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            op_sub,
    input  logic [LANES*(INT_BITS+FRAC_BITS)-1:0] a,
    input  logic [LANES*(INT_BITS+FRAC_BITS)-1:0] b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*(INT_BITS+FRAC_BITS)-1:0] result,
    output logic [LANES-1:0]                flag_n,
    output logic [LANES-1:0]                flag_v,
    output logic [LANES-1:0]                flag_z,
    output logic                            sticky_v,
    input  logic                            clr_sticky
);

    localparam int W = INT_BITS + FRAC_BITS;

    // Exact sum of two sign-extended lanes; subtraction as x + ~y + 1.
    function automatic logic signed [W:0] add_sub(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y,
                                                  input logic sub);
        logic signed [W:0] xe;
        logic signed [W:0] ye;
        xe = {x[W-1], x};
        ye = {y[W-1], y};
        if (sub) ye = ~ye;
        return xe + ye + {{W{1'b0}}, sub};
    endfunction

    // Reduce the exact sum to W bits: clamp to the range limits on overflow
    // when saturating, otherwise keep the low W bits (two's-complement wrap).
    function automatic logic signed [W-1:0] clamp(input logic signed [W:0] s);
        logic signed [W-1:0] r;
        r = s[W-1:0];
        if ((SATURATE != 0) && (s[W] != s[W-1])) begin
            r = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return r;
    endfunction

    logic                vld_p1;
    logic signed [W:0]   sum_p1 [LANES];
    logic signed [W:0]   sum_next [LANES];

    logic [LANES*W-1:0]  res_next;
    logic [LANES-1:0]    n_next;
    logic [LANES-1:0]    v_next;
    logic [LANES-1:0]    z_next;

    logic                s2_advance;
    logic                s1_advance;
    logic                in_fire;
    logic                out_fire;

    // A stage moves when it is empty or the stage after it is moving.
    always_comb begin
        s2_advance = ~out_valid | out_ready;
        s1_advance = ~vld_p1 | s2_advance;
        in_ready   = s1_advance;
        in_fire    = in_valid & s1_advance;
        out_fire   = out_valid & out_ready;
    end

    // Per-lane exact sums for the incoming operand set.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sum_next[i] = add_sub(a[i*W +: W], b[i*W +: W], op_sub);
        end
    end

    // Per-lane final result and flags from the stage-1 sums.
    always_comb begin
        res_next = '0;
        n_next   = '0;
        v_next   = '0;
        z_next   = '0;
        for (int i = 0; i < LANES; i++) begin
            res_next[i*W +: W] = clamp(sum_p1[i]);
            v_next[i]          = sum_p1[i][W] ^ sum_p1[i][W-1];
            n_next[i]          = res_next[i*W + W - 1];
            z_next[i]          = (res_next[i*W +: W] == '0);
        end
    end

    // ---- stage 1: capture exact sums on input handshake ----
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < LANES; i++) begin
                sum_p1[i] <= sum_next[i];
            end
        end
    end

    // Stage valid bits; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s1_advance) vld_p1 <= in_valid;
            if (s2_advance) out_valid <= vld_p1;
        end
    end

    // ---- stage 2: result and flags, held while the consumer stalls ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            flag_n <= '0;
            flag_v <= '0;
            flag_z <= '0;
        end else if (s2_advance && vld_p1) begin
            result <= res_next;
            flag_n <= n_next;
            flag_v <= v_next;
            flag_z <= z_next;
        end
    end

    // Sticky overflow: set on a delivered overflowing beat, set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= 1'b0;
        end else if (out_fire && (|flag_v)) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fixed_addsub_pipe.sv
// Directed bench for fixed_addsub_pipe: table of single-beat vectors (Q7.8,
// 4 lanes) on a saturating and a wrapping instance, then hand sequences for
// sticky clear/set priority, backpressure and mid-flight reset.
module tb_fixed_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_ready = 1'b1;
    logic        clr_sticky = 1'b0;

    logic        in_ready, out_valid, sticky_v;
    logic [63:0] result;
    logic [3:0]  flag_n, flag_v, flag_z;

    logic        w_in_ready, w_out_valid, w_sticky_v;
    logic [63:0] w_result;
    logic [3:0]  w_flag_n, w_flag_v, w_flag_z;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fixed_addsub_pipe #(.INT_BITS(8), .FRAC_BITS(8), .LANES(4), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z),
        .sticky_v(sticky_v), .clr_sticky(clr_sticky));

    fixed_addsub_pipe #(.INT_BITS(8), .FRAC_BITS(8), .LANES(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .op_sub(op_sub), .a(a), .b(b), .out_valid(w_out_valid), .out_ready(out_ready),
        .result(w_result), .flag_n(w_flag_n), .flag_v(w_flag_v), .flag_z(w_flag_z),
        .sticky_v(w_sticky_v), .clr_sticky(clr_sticky));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sub;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [63:0] res_wrap;
        logic [3:0]  n;
        logic [3:0]  v;
        logic [3:0]  z;
        logic        sticky;
    } vec_t;

    vec_t vecs [6];

    // Present one beat, check latency, then check the delivered result.
    // Starts and ends on a falling edge; the output handshake follows.
    task automatic run_vec(input int k);
        in_valid  = 1'b1;
        op_sub    = vecs[k].sub;
        a         = vecs[k].a;
        b         = vecs[k].b;
        out_ready = 1'b1;
        #1 chk($sformatf("v%0d in_ready", k), {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("v%0d out_valid after 1 clk", k), {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d out_valid after 2 clk", k), {63'd0, out_valid}, 64'd1);
        chk($sformatf("v%0d result", k), result, vecs[k].res);
        chk($sformatf("v%0d flag_n", k), {60'd0, flag_n}, {60'd0, vecs[k].n});
        chk($sformatf("v%0d flag_v", k), {60'd0, flag_v}, {60'd0, vecs[k].v});
        chk($sformatf("v%0d flag_z", k), {60'd0, flag_z}, {60'd0, vecs[k].z});
        chk($sformatf("v%0d sticky_v", k), {63'd0, sticky_v}, {63'd0, vecs[k].sticky});
        chk($sformatf("v%0d wrap result", k), w_result, vecs[k].res_wrap);
        chk($sformatf("v%0d wrap flag_v", k), {60'd0, w_flag_v}, {60'd0, vecs[k].v});
    endtask

    logic [63:0] bp_exp [6];
    logic [63:0] held;
    logic        was_stalled;
    int          sent, recv, stale;
    logic        acc, dlv;

    initial begin
        //            sub   a                     b                     res (sat)             res (wrap)            N      V      Z      sticky
        vecs[0] = '{1'b1, 64'h0000_0000_0000_0180, 64'h0000_0000_0000_0040, 64'h0000_0000_0000_0140, 64'h0000_0000_0000_0140, 4'b0000, 4'b0000, 4'b1110, 1'b0};
        vecs[1] = '{1'b1, 64'h0000_0000_0080_0100, 64'h0000_0000_0100_0080, 64'h0000_0000_FF80_0080, 64'h0000_0000_FF80_0080, 4'b0010, 4'b0000, 4'b1100, 1'b0};
        vecs[2] = '{1'b1, 64'h1234_7FFF_8000_7F00, 64'h1234_FFFF_0100_8000, 64'h0000_7FFF_8000_7FFF, 64'h0000_8000_7F00_FF00, 4'b0010, 4'b0111, 4'b1000, 1'b0};
        vecs[3] = '{1'b0, 64'hFFFF_00FF_7F00_8000, 64'h0001_0001_0100_FF00, 64'h0000_0100_7FFF_8000, 64'h0000_0100_8000_7F00, 4'b0001, 4'b0011, 4'b1000, 1'b1};
        vecs[4] = '{1'b1, 64'hC000_0001_ABCD_0300, 64'h4000_FFFF_ABCD_0500, 64'h8000_0002_0000_FE00, 64'h8000_0002_0000_FE00, 4'b1001, 4'b0000, 4'b0010, 1'b1};
        vecs[5] = '{1'b0, 64'h4000_4000_0000_FFFF, 64'h4000_3FFF_0000_FFFF, 64'h7FFF_7FFF_0000_FFFE, 64'h8000_7FFF_0000_FFFE, 4'b0001, 4'b1000, 4'b0010, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset result", result, 64'd0);
        chk("reset flags", {52'd0, flag_n, flag_v, flag_z}, 64'd0);
        chk("reset sticky_v", {63'd0, sticky_v}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Sticky holds, then a lone clear drops it.
        repeat (3) @(negedge clk);
        chk("sticky held", {63'd0, sticky_v}, 64'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky cleared", {63'd0, sticky_v}, 64'd0);

        // Clear coincident with an overflowing output handshake: set wins.
        run_vec(2);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("sticky set beats clear", {63'd0, sticky_v}, 64'd1);

        // Backpressure: 6 beats, consumer stalls in cycles 3..6.
        for (int k = 0; k < 6; k++) begin
            bp_exp[k] = {4{16'(k * 256 + 1)}};
        end
        sent = 0;
        recv = 0;
        was_stalled = 1'b0;
        held = '0;
        op_sub = 1'b0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            in_valid  = (sent < 6);
            a         = {4{16'(sent * 256)}};
            b         = {4{16'h0001}};
            out_ready = !(c >= 3 && c <= 6);
            #1;
            acc = in_valid & in_ready;
            dlv = out_valid & out_ready;
            chk($sformatf("bp c%0d in_ready", c), {63'd0, in_ready},
                {63'd0, ((sent - recv) < 2) || out_ready});
            if (was_stalled) chk($sformatf("bp c%0d stall hold", c), result, held);
            if (dlv) begin
                chk($sformatf("bp beat%0d result", recv), result, bp_exp[recv]);
                recv++;
            end
            if (acc) sent++;
            was_stalled = out_valid & ~out_ready;
            held = result;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp all beats delivered", 64'(recv), 64'd6);

        // Reset with two beats in flight and sticky set.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = {4{16'h0100}};
        b = {4{16'h0100}};
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("pre-reset in_ready", {63'd0, in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("async reset sticky_v", {63'd0, sticky_v}, 64'd0);
        chk("async reset result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no stale beat after reset", 64'(stale), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
